// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master MIPS bus arbiter.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/mips_bus_arb_pick.sv
// Combinational requester picker; MIPS_BUS_ARB_RR_EN selects round-robin,
// otherwise M0 has fixed priority and `last` is ignored.
module mips_bus_arb_pick
  import mips_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick
);

`ifdef MIPS_BUS_ARB_RR_EN
  always_comb begin
    pick = GNT_NONE;
    if (req == 2'b11) pick = (last == GNT_M0) ? GNT_M1 : GNT_M0;
    else if (req[0])  pick = GNT_M0;
    else if (req[1])  pick = GNT_M1;
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    pick = GNT_NONE;
    if (req[0])      pick = GNT_M0;
    else if (req[1]) pick = GNT_M1;
  end
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave Avalon-style arbiter with per-transfer stall watchdog.
// Define MIPS_BUS_ARB_RR_EN for round-robin tie-break (default: M0 priority).
//   state | meaning
//   IDLE  | no owner, slave strobes low, picking next requester
//   GNT0  | M0 owns the slave until s_waitrequest=0 or watchdog abort
//   GNT1  | M1 owns the slave until s_waitrequest=0 or watchdog abort
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ABORT_DATA     = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int             CNT_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit             WDOG_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic [1:0]       req, last, pick;
  logic             abort;

  assign req   = {m1_read | m1_write, m0_read | m0_write};
  assign abort = WDOG_EN && (state_q != IDLE) && (cnt_q == TO_VAL);

  mips_bus_arb_pick u_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

`ifdef MIPS_BUS_ARB_RR_EN
  logic [1:0] last_q, last_d;

  assign last_d = (state_q == IDLE && pick != GNT_NONE) ? pick : last_q;
  assign last   = last_q;

  always_ff @(posedge clk) begin
    if (!reset_n) last_q <= GNT_M1;
    else          last_q <= last_d;
  end
`else
  assign last = GNT_M1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick == GNT_M0)      state_d = GNT0;
        else if (pick == GNT_M1) state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (abort) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Owner's fields pass straight through; an abort kills the strobes and fakes a completion.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    grant          = GNT_NONE;
    case (state_q)
      GNT0: begin
        grant          = GNT_M0;
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        s_write        = m0_write & ~abort;
        s_read         = m0_read & ~m0_write & ~abort;
        m0_waitrequest = s_waitrequest & ~abort;
        m0_readdata    = abort ? ABORT_DATA : s_readdata;
      end
      GNT1: begin
        grant          = GNT_M1;
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        s_write        = m1_write & ~abort;
        s_read         = m1_read & ~m1_write & ~abort;
        m1_waitrequest = s_waitrequest & ~abort;
        m1_readdata    = abort ? ABORT_DATA : s_readdata;
      end
      default: ;
    endcase
  end

  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter with a small stallable RAM model.
// Honours MIPS_BUS_ARB_RR_EN for the tie-break expectations.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_read, m0_write, m0_waitrequest;
  logic [3:0]  m0_byteenable;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest;
  logic [3:0]  m1_byteenable;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(8), .ABORT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .timeout_err(timeout_err)
  );

  // RAM model: 16 words, stall_cfg wait states per transfer, or stuck busy
  logic [31:0] mem [0:15];
  bit          mem_loaded;
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  bit          stuck = 1'b0;

  assign s_readdata    = mem[s_address[5:2]];
  assign s_waitrequest = stuck || ((s_read || s_write) && stall_cnt != 0);

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
      mem_loaded <= 1'b1;
    end else if (s_write && !s_waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) mem[s_address[5:2]][8*b +: 8] <= s_writedata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (!(s_read || s_write))  stall_cnt <= stall_cfg;
    else if (stall_cnt != 0)   stall_cnt <= stall_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g [0:4];
    logic [1:0] seen_g [0:4];
    int         n_g, stall_seen, gcyc, abort_cyc;
    bit         done, m0_seen;
    logic [31:0] abort_rd;
    logic        abort_srd;

`ifdef MIPS_BUS_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif

    reset_n = 1'b0;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 4'hF;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);
    check("rst_s_read", {31'd0, s_read}, 32'd0);
    check("rst_s_write", {31'd0, s_write}, 32'd0);
    check("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    check("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    check("rst_m0_rdata", m0_readdata, 32'd0);
    check("rst_m1_rdata", m1_readdata, 32'd0);

    // M0 zero-wait read of 0x10
    next_cycle();
    reset_n = 1'b1;
    m0_address = 32'h10; m0_read = 1'b1;
    @(negedge clk);
    check("t1_n_grant", {30'd0, grant}, 32'd0);
    check("t1_n_s_read", {31'd0, s_read}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t1_n1_s_read", {31'd0, s_read}, 32'd1);
    check("t1_n1_grant", {30'd0, grant}, 32'd1);
    check("t1_n1_s_addr", s_address, 32'h10);
    check("t1_n1_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
    check("t1_n1_m0_rdata", m0_readdata, 32'h1000_0004);
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    check("t1_n2_grant", {30'd0, grant}, 32'd0);
    check("t1_n2_m0_wait", {31'd0, m0_waitrequest}, 32'd1);

    // Both masters request; M0 drops after its 4th grant
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    m0_address = 32'h0; m0_read = 1'b1;
    m1_address = 32'h4; m1_read = 1'b1;
    n_g = 0;
    for (int c = 0; c < 40 && n_g < 5; c++) begin
      @(negedge clk);
      if (grant != 2'b00) begin
        seen_g[n_g] = grant;
        n_g++;
        if (n_g == 4) begin
          next_cycle();
          m0_read = 1'b0;
        end
      end
    end
    check("t2_count", n_g, 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < n_g) check($sformatf("t2_grant%0d", i), {30'd0, seen_g[i]}, {30'd0, exp_g[i]});
    next_cycle();
    m1_read = 1'b0;

    // M1 partial write with 3 wait states, M0 requesting meanwhile
    next_cycle();
    stall_cfg = 3;
    m1_address = 32'h20; m1_write = 1'b1; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'b0011;
    @(negedge clk);
    stall_seen = 0; done = 0; m0_seen = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      next_cycle();
      if (c == 0) begin
        m0_address = 32'h0; m0_read = 1'b1;
      end
      @(negedge clk);
      if (grant == 2'b01) m0_seen = 1;
      if (grant == 2'b10) begin
        if (m1_waitrequest) stall_seen++;
        else done = 1;
      end
    end
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_stalls", stall_seen, 32'd3);
    check("t3_m0_blocked", {31'd0, m0_seen}, 32'd0);
    next_cycle();
    m1_write = 1'b0; m1_byteenable = 4'hF;
    stall_cfg = 0;
    @(negedge clk);
    check("t3_ram", mem[8], 32'h1000_F00D);
    check("t3_bubble", {30'd0, grant}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t3_m0_grant", {30'd0, grant}, 32'd1);
    check("t3_m0_rdata", m0_readdata, 32'h1000_0000);
    next_cycle();
    m0_read = 1'b0;

    // Watchdog abort with slave stuck busy
    next_cycle();
    stuck = 1'b1;
    m0_address = 32'h10; m0_read = 1'b1;
    gcyc = 0; abort_cyc = 0; abort_rd = '0; abort_srd = 1'b1;
    for (int c = 0; c < 20 && abort_cyc == 0; c++) begin
      @(negedge clk);
      if (grant == 2'b01) begin
        gcyc++;
        if (!m0_waitrequest) begin
          abort_cyc = gcyc;
          abort_rd  = m0_readdata;
          abort_srd = s_read;
        end
      end
      if (abort_cyc == 0) next_cycle();
    end
    check("t4_abort_cycle", abort_cyc, 32'd9);
    check("t4_abort_data", abort_rd, 32'hDEADBEEF);
    check("t4_abort_s_read", {31'd0, abort_srd}, 32'd0);
    next_cycle();
    stuck = 1'b0;
    m0_read = 1'b0;
    @(negedge clk);
    check("t4_terr_set", {31'd0, timeout_err}, 32'd1);
    check("t4_idle", {30'd0, grant}, 32'd0);
    next_cycle();
    m1_address = 32'h4; m1_read = 1'b1;
    next_cycle();
    @(negedge clk);
    check("t4_m1_grant", {30'd0, grant}, 32'd2);
    check("t4_m1_rdata", m1_readdata, 32'h1000_0001);
    next_cycle();
    m1_read = 1'b0;
    @(negedge clk);
    check("t4_terr_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of a stalled transfer
    next_cycle();
    stall_cfg = 5;
    m0_address = 32'h10; m0_read = 1'b1;
    next_cycle();
    @(negedge clk);
    check("t5_stalled", {30'd0, grant}, 32'd1);
    check("t5_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    next_cycle();
    reset_n = 1'b0;
    m0_read = 1'b0;
    next_cycle();
    @(negedge clk);
    check("t5_rst_grant", {30'd0, grant}, 32'd0);
    check("t5_rst_s_read", {31'd0, s_read}, 32'd0);
    check("t5_rst_terr", {31'd0, timeout_err}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    stall_cfg = 0;
    m1_address = 32'h8; m1_read = 1'b1;
    @(negedge clk);
    check("t5_post_idle", {30'd0, grant}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t5_m1_grant", {30'd0, grant}, 32'd2);
    check("t5_m1_wait", {31'd0, m1_waitrequest}, 32'd0);
    check("t5_m1_rdata", m1_readdata, 32'h1000_0002);
    next_cycle();
    m1_read = 1'b0;
    @(negedge clk);
    check("t5_done_idle", {30'd0, grant}, 32'd0);

    // Read and write together: only the write reaches the slave
    next_cycle();
    m0_address = 32'h30; m0_read = 1'b1; m0_write = 1'b1;
    m0_writedata = 32'h1234_5678; m0_byteenable = 4'hF;
    next_cycle();
    @(negedge clk);
    check("t6_grant", {30'd0, grant}, 32'd1);
    check("t6_s_write", {31'd0, s_write}, 32'd1);
    check("t6_s_read", {31'd0, s_read}, 32'd0);
    next_cycle();
    m0_read = 1'b0; m0_write = 1'b0;
    @(negedge clk);
    check("t6_ram", mem[12], 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
